cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss/refill controller for the 2-way set-associative cache.
//  Owns the per-set tag/valid/dirty arrays and a 1-bit-per-set LRU victim selector.
//  Sequences lookup, dirty-victim writeback and line refill between the CPU port and the memory port.
//  Drives the external data-RAM way/word/write-enable; the data RAM itself lives outside this block.
// PARAMETERS
//  ADDR_W    32  byte-address width
//  INDEX_W   6   set index bits (NSETS = 2**INDEX_W)
//  WORDS     4   32-bit words per line (power of 2); OFFSET_W = log2(WORDS)+2, TAG_W = ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       asynchronous, active-low reset
//  cpu_req_valid   in   1       CPU request present
//  cpu_req_ready   out  1       1 only in IDLE with rst high
//  cpu_req_addr    in   ADDR_W  request byte address
//  cpu_req_we      in   1       1 = store (marks line dirty)
//  cpu_resp_valid  out  1       1-cycle pulse: line resident, access way in resp_way
//  cpu_resp_hit    out  1       qualifies cpu_resp_valid: 1 = hit, 0 = filled after miss
//  resp_way        out  1       way holding the requested line
//  mem_req_valid   out  1       memory burst request
//  mem_req_ready   in   1       memory accepts request
//  mem_req_we      out  1       1 = writeback burst, 0 = refill burst
//  mem_req_addr    out  ADDR_W  line-aligned burst address (offset bits zero)
//  mem_wvalid      out  1       writeback beat valid (data read from data RAM at dram_way/dram_word)
//  mem_wready      in   1       memory consumes writeback beat
//  mem_rvalid      in   1       refill beat valid (data goes straight to data RAM)
//  dram_way        out  1       data-RAM way select
//  dram_word       out  log2(WORDS)  data-RAM word select
//  dram_we         out  1       data-RAM write enable (refill beat)
// BEHAVIOUR
//  - Reset (rst=0, any state):
//    - state=IDLE; all valid/dirty/LRU bits 0; beat counter 0.
//    - All outputs 0, including cpu_req_ready.
//    - Any burst in flight is abandoned; no outstanding-transaction tracking survives.
//  - States: IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, RESP.
//  - IDLE: ready=1. On valid&ready, register addr/we -> LOOKUP.
//  - LOOKUP (1 cycle): compare the tag with both ways of the set.
//    - Hit on way0 and way1 both is impossible; if it occurs, way0 wins.
//    - Hit: lru[set] <= ~hit_way; if we, dirty[hit_way] <= 1 -> RESP with hit=1.
//    - Miss, victim selection:
//      - way0 invalid -> way0;
//      - else way1 invalid -> way1;
//      - else lru[set].
//    - Miss, next state: victim valid&dirty -> WB_REQ, else RF_REQ.
//  - WB_REQ: mem_req_valid=1, we=1, addr={victim_tag,index,0}; hold until mem_req_ready -> WB_DATA.
//  - WB_DATA: mem_wvalid=1, dram_way=victim, dram_word=cnt.
//    - cnt++ on mem_wready.
//    - Beat WORDS-1 accepted -> cnt wraps to 0 -> RF_REQ.
//  - RF_REQ: mem_req_valid=1, we=0, addr={req_tag,index,0}; on ready -> RF_DATA.
//  - RF_DATA: dram_we=mem_rvalid, dram_way=victim, dram_word=cnt; cnt++ per rvalid.
//    - On the last beat: tag[victim]<=req_tag, valid<=1, dirty<=req_we, lru[set]<=~victim, cnt wraps to 0.
//    - Then -> RESP with hit=0.
//  - RESP: cpu_resp_valid=1 one cycle, resp_way set -> IDLE. Next request is accepted the cycle after.
//  - Latency: hit = req accept + 2 cycles to resp_valid. Miss = hit latency + memory time.
//  - mem_req_valid, once raised, stays high with a stable address until ready.
//  - Beats with valid low do not advance cnt.
//  - mem_rvalid outside RF_DATA is ignored.
//  - A new CPU request during a miss is impossible (ready=0); the CPU holds it.
// TESTING
//  1. Reset, read 0x0000_1040 (set 4), 4 rvalid beats
//     -> refill to way0, dram_word 0..3, resp hit=0 way0, lru[4]=1.
//  2. Repeat read 0x0000_1040
//     -> resp_valid 2 cycles after accept, hit=1 way0, no mem_req.
//  3. Read 0x0000_2040 (same set)
//     -> way1 filled, lru[4]=0; then read 0x0000_3040 -> victim way0 (clean), no writeback.
//  4. Store 0x0000_2040 (hit, dirty way1), then read 0x0000_4040 and 0x0000_5040
//     -> second miss evicts way1: WB_REQ addr 0x0000_2040, 4 wbeats, then RF_REQ 0x0000_5040.
//  5. Stall mem_wready/mem_rvalid low for 5 cycles mid-burst
//     -> cnt and outputs hold; burst completes correctly afterward.
//  6. Assert rst low during RF_DATA beat 2
//     -> all outputs 0 immediately; after release, ready=1 and the previously filled line misses.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// Buses of the cache refill controller.
//   cache_cpu_if : CPU request/response port (master = CPU, slave = controller)
//   cache_mem_if : memory burst port plus the external data-RAM controls
//                  (master = controller, slave = memory/data RAM)
interface cache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_we;
  logic              cpu_resp_valid;
  logic              cpu_resp_hit;
  logic              resp_way;

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_we,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, resp_way
  );

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_we,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, resp_way
  );
endinterface

interface cache_mem_if #(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 4
);
  localparam int CNT_W = $clog2(WORDS);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wvalid;
  logic              mem_wready;
  logic              mem_rvalid;
  logic              dram_way;
  logic [CNT_W-1:0]  dram_word;
  logic              dram_we;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid,
           dram_way, dram_word, dram_we,
    input  mem_req_ready, mem_wready, mem_rvalid
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid,
           dram_way, dram_word, dram_we,
    output mem_req_ready, mem_wready, mem_rvalid
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller for a 2-way set-associative cache.
// Holds tag/valid/dirty per way and set plus one LRU bit per set, and
// sequences lookup, dirty-victim writeback and line refill. The data RAM is
// external; this block only steers its way/word/write-enable.
module cache_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int WORDS   = 4
) (
  input  logic        clk,
  input  logic        rst,   // active-low, asynchronous
  cache_cpu_if.slave  cpu,
  cache_mem_if.master mem
);

  localparam int CNT_W    = $clog2(WORDS);
  localparam int OFFSET_W = CNT_W + 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NSETS    = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, RESP
  } state_t;

  state_t state_reg, state_next;

  logic [TAG_W-1:0]         tag_reg;         // tag of the captured request
  logic [INDEX_W-1:0]       index_reg;       // set of the captured request
  logic                     we_reg;
  logic                     victim_reg;
  logic [TAG_W-1:0]         victim_tag_reg;  // tag of the line being evicted
  logic [CNT_W-1:0]         cnt_reg;         // beat counter for both bursts
  logic                     resp_hit_reg;
  logic                     resp_way_reg;
  logic [1:0][NSETS-1:0]    valid_reg;
  logic [1:0][NSETS-1:0]    dirty_reg;
  logic [NSETS-1:0]         lru_reg;         // way to evict next when both valid

  logic [1:0][TAG_W-1:0]    tag_rd;
  logic [1:0]               hit;
  logic                     hit_way;
  logic                     victim_sel;
  logic                     victim_dirty;
  logic                     req_fire;
  logic                     cnt_last;
  logic                     fill_done;
  logic                     unused_addr_bits;

  assign req_fire  = cpu.cpu_req_valid && cpu.cpu_req_ready;
  assign cnt_last  = (cnt_reg == CNT_W'(WORDS - 1));
  assign fill_done = (state_reg == RF_DATA) && mem.mem_rvalid && cnt_last;
  assign hit_way   = ~hit[0];   // way0 wins if both ever match
  assign unused_addr_bits = ^cpu.cpu_req_addr[OFFSET_W-1:0];

  // Per-way tag storage: the tag is read into a register when the request is
  // accepted so LOOKUP compares registered values; written on the final refill beat.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem [NSETS];
      logic [TAG_W-1:0] tag_rd_reg;

      // Tag write on refill completion, registered tag read on request accept
      always_ff @(posedge clk) begin
        if (fill_done && (victim_reg == 1'(gi))) begin
          tag_mem[index_reg] <= tag_reg;
        end
        if (req_fire) begin
          tag_rd_reg <= tag_mem[cpu.cpu_req_addr[OFFSET_W +: INDEX_W]];
        end
      end

      assign tag_rd[gi] = tag_rd_reg;
      assign hit[gi]    = valid_reg[gi][index_reg] && (tag_rd_reg == tag_reg);
    end
  endgenerate

  // Victim choice on a miss: first invalid way, otherwise the LRU way
  always_comb begin
    if (!valid_reg[0][index_reg]) begin
      victim_sel = 1'b0;
    end else if (!valid_reg[1][index_reg]) begin
      victim_sel = 1'b1;
    end else begin
      victim_sel = lru_reg[index_reg];
    end
    victim_dirty = valid_reg[victim_sel][index_reg] && dirty_reg[victim_sel][index_reg];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_fire) state_next = LOOKUP;
      LOOKUP: begin
        if (|hit)              state_next = RESP;
        else if (victim_dirty) state_next = WB_REQ;
        else                   state_next = RF_REQ;
      end
      WB_REQ:  if (mem.mem_req_ready) state_next = WB_DATA;
      WB_DATA: if (mem.mem_wready && cnt_last) state_next = RF_REQ;
      RF_REQ:  if (mem.mem_req_ready) state_next = RF_DATA;
      RF_DATA: if (mem.mem_rvalid && cnt_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state; everything is 0 under reset
  always_comb begin
    cpu.cpu_req_ready  = 1'b0;
    cpu.cpu_resp_valid = 1'b0;
    cpu.cpu_resp_hit   = 1'b0;
    cpu.resp_way       = 1'b0;
    mem.mem_req_valid  = 1'b0;
    mem.mem_req_we     = 1'b0;
    mem.mem_req_addr   = '0;
    mem.mem_wvalid     = 1'b0;
    mem.dram_way       = 1'b0;
    mem.dram_word      = '0;
    mem.dram_we        = 1'b0;
    case (state_reg)
      IDLE:    cpu.cpu_req_ready = rst;
      WB_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        mem.mem_req_addr  = {victim_tag_reg, index_reg, {OFFSET_W{1'b0}}};
      end
      WB_DATA: begin
        mem.mem_wvalid = 1'b1;
        mem.dram_way   = victim_reg;
        mem.dram_word  = cnt_reg;
      end
      RF_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = {tag_reg, index_reg, {OFFSET_W{1'b0}}};
      end
      RF_DATA: begin
        mem.dram_we   = mem.mem_rvalid;
        mem.dram_way  = victim_reg;
        mem.dram_word = cnt_reg;
      end
      RESP: begin
        cpu.cpu_resp_valid = 1'b1;
        cpu.cpu_resp_hit   = resp_hit_reg;
        cpu.resp_way       = resp_way_reg;
      end
      default: ;
    endcase
  end

  // Request capture, lookup bookkeeping, beat counting and line install
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_reg        <= '0;
      index_reg      <= '0;
      we_reg         <= 1'b0;
      victim_reg     <= 1'b0;
      victim_tag_reg <= '0;
      cnt_reg        <= '0;
      resp_hit_reg   <= 1'b0;
      resp_way_reg   <= 1'b0;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      lru_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            tag_reg   <= cpu.cpu_req_addr[ADDR_W-1 -: TAG_W];
            index_reg <= cpu.cpu_req_addr[OFFSET_W +: INDEX_W];
            we_reg    <= cpu.cpu_req_we;
          end
        end
        LOOKUP: begin
          if (|hit) begin
            lru_reg[index_reg] <= ~hit_way;
            if (we_reg) begin
              dirty_reg[hit_way][index_reg] <= 1'b1;
            end
            resp_hit_reg <= 1'b1;
            resp_way_reg <= hit_way;
          end else begin
            victim_reg     <= victim_sel;
            victim_tag_reg <= tag_rd[victim_sel];
          end
        end
        WB_DATA: begin
          if (mem.mem_wready) begin
            cnt_reg <= cnt_reg + 1'b1;   // wraps to 0 after the last beat
          end
        end
        RF_DATA: begin
          if (mem.mem_rvalid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_last) begin
              valid_reg[victim_reg][index_reg] <= 1'b1;
              dirty_reg[victim_reg][index_reg] <= we_reg;
              lru_reg[index_reg]               <= ~victim_reg;
              resp_hit_reg                     <= 1'b0;
              resp_way_reg                     <= victim_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl. A reference cache model turns
// every CPU access into the ordered list of bus events it must cause; a
// monitor pops and compares them as the DUT produces them.
module tb_cache_refill_ctrl;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 6;
  localparam int WORDS   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_cpu_if #(.ADDR_W(ADDR_W)) cpu_bus ();
  cache_mem_if #(.ADDR_W(ADDR_W), .WORDS(WORDS)) mem_bus ();

  cache_refill_ctrl #(
    .ADDR_W (ADDR_W),
    .INDEX_W(INDEX_W),
    .WORDS  (WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu(cpu_bus),
    .mem(mem_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- event encoding ----------------
  function automatic logic [63:0] ev_req(input logic we, input logic [31:0] addr);
    return {24'd0, 4'd0, 3'd0, we, addr};
  endfunction
  function automatic logic [63:0] ev_wb(input logic way, input logic [1:0] word);
    return {24'd0, 4'd1, 33'd0, way, word};
  endfunction
  function automatic logic [63:0] ev_rf(input logic way, input logic [1:0] word);
    return {24'd0, 4'd2, 33'd0, way, word};
  endfunction
  function automatic logic [63:0] ev_resp(input logic hit, input logic way);
    return {24'd0, 4'd3, 34'd0, hit, way};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {21'd0, cpu_bus.cpu_req_ready, cpu_bus.cpu_resp_valid, cpu_bus.cpu_resp_hit,
            cpu_bus.resp_way, mem_bus.mem_req_valid, mem_bus.mem_req_we,
            mem_bus.mem_req_addr, mem_bus.mem_wvalid, mem_bus.dram_way,
            mem_bus.dram_word, mem_bus.dram_we};
  endfunction

  logic [63:0] exp_q [$];

  // ---------------- reference cache model ----------------
  logic [21:0] m_tag   [2][64];
  logic        m_valid [2][64];
  logic        m_dirty [2][64];
  logic        m_lru   [64];

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[0][s] = 1'b0; m_valid[1][s] = 1'b0;
      m_dirty[0][s] = 1'b0; m_dirty[1][s] = 1'b0;
      m_lru[s] = 1'b0;
    end
  endtask

  // ---------------- memory responder + monitor ----------------
  int          cyc = 0;
  int          accept_cyc = 0;
  bit          accepted = 0;
  int          stall_cycles = 0;
  int          stall_arm = 0;
  int          burst_beats = 0;
  bit          stall_first = 0;
  logic [63:0] stall_snap = '0;
  bit          req_pend = 0;
  logic [32:0] req_snap = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_wready    = 1'b0;
    mem_bus.mem_rvalid    = 1'b0;
    forever begin
      bit          stalled;
      bit          have;
      bit          is_beat;
      string       name;
      logic [63:0] obs;
      @(negedge clk);
      stalled = (stall_cycles > 0);
      if (stalled) begin
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_wready    = 1'b0;
        mem_bus.mem_rvalid    = 1'b0;
        stall_cycles--;
      end else begin
        mem_bus.mem_req_ready = 1'($urandom_range(0, 1));
        mem_bus.mem_wready    = 1'($urandom_range(0, 1));
        mem_bus.mem_rvalid    = 1'($urandom_range(0, 1));
      end
      #1;
      if (stalled) begin
        if (stall_first) begin
          check_eq("stall_word", 64'(mem_bus.dram_word), 64'd2);
          stall_snap  = all_outputs();
          stall_first = 0;
        end else begin
          check_eq("stall_hold", all_outputs(), stall_snap);
        end
      end
      if (req_pend) begin
        check_eq("req_hold", {31'd0, mem_bus.mem_req_valid, mem_bus.mem_req_we, mem_bus.mem_req_addr},
                 {31'd0, 1'b1, req_snap});
      end
      req_pend = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
      req_snap = {mem_bus.mem_req_we, mem_bus.mem_req_addr};

      have = 0; is_beat = 0; obs = '0; name = "";
      if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        obs = ev_req(mem_bus.mem_req_we, mem_bus.mem_req_addr); name = "mem_req";
        have = 1; burst_beats = 0;
      end else if (mem_bus.mem_wvalid && mem_bus.mem_wready) begin
        obs = ev_wb(mem_bus.dram_way, mem_bus.dram_word); name = "wb_beat";
        have = 1; is_beat = 1;
      end else if (mem_bus.dram_we) begin
        obs = ev_rf(mem_bus.dram_way, mem_bus.dram_word); name = "rf_beat";
        have = 1; is_beat = 1;
      end else if (cpu_bus.cpu_resp_valid) begin
        obs = ev_resp(cpu_bus.cpu_resp_hit, cpu_bus.resp_way); name = "cpu_resp";
        have = 1;
        if (cpu_bus.cpu_resp_hit) begin
          check_eq("hit_latency", 64'(cyc - accept_cyc), 64'd2);
        end
      end
      if (have) begin
        if (exp_q.size() == 0) check_eq({"spurious_", name}, obs, '1);
        else                   check_eq(name, obs, exp_q.pop_front());
      end
      if (is_beat) begin
        if (burst_beats == 1 && stall_arm > 0) begin
          stall_cycles = 5;
          stall_arm--;
          stall_first = 1;
        end
        burst_beats++;
      end
      if (cpu_bus.cpu_req_valid && cpu_bus.cpu_req_ready) begin
        accept_cyc = cyc;
        accepted   = 1;
      end
    end
  end

  // ---------------- CPU-side stimulus ----------------
  task automatic issue(input logic [31:0] addr, input logic we);
    int n = 0;
    accepted = 0;
    @(negedge clk);
    cpu_bus.cpu_req_addr  = addr;
    cpu_bus.cpu_req_we    = we;
    cpu_bus.cpu_req_valid = 1'b1;
    #2;
    while (!accepted && n < 50) begin
      @(negedge clk); #2; n++;
    end
    check_eq("accept", 64'(accepted), 64'd1);
    @(posedge clk); #1;
    cpu_bus.cpu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #2; n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic access(input logic [31:0] addr, input logic we);
    logic [5:0]  idx;
    logic [21:0] tg;
    logic        h0, h1;
    logic        v;
    idx = addr[9:4];
    tg  = addr[31:10];
    h0  = m_valid[0][idx] && (m_tag[0][idx] == tg);
    h1  = m_valid[1][idx] && (m_tag[1][idx] == tg);
    if (h0 || h1) begin
      v = h0 ? 1'b0 : 1'b1;
      m_lru[idx] = ~v;
      if (we) m_dirty[v][idx] = 1'b1;
      exp_q.push_back(ev_resp(1'b1, v));
    end else begin
      if (!m_valid[0][idx])      v = 1'b0;
      else if (!m_valid[1][idx]) v = 1'b1;
      else                       v = m_lru[idx];
      if (m_valid[v][idx] && m_dirty[v][idx]) begin
        exp_q.push_back(ev_req(1'b1, {m_tag[v][idx], idx, 4'b0000}));
        for (int w = 0; w < WORDS; w++) exp_q.push_back(ev_wb(v, 2'(w)));
      end
      exp_q.push_back(ev_req(1'b0, {addr[31:4], 4'b0000}));
      for (int w = 0; w < WORDS; w++) exp_q.push_back(ev_rf(v, 2'(w)));
      exp_q.push_back(ev_resp(1'b0, v));
      m_tag[v][idx]   = tg;
      m_valid[v][idx] = 1'b1;
      m_dirty[v][idx] = we;
      m_lru[idx]      = ~v;
    end
    $display("access addr=0x%08h we=%0d expect %s way%0d", addr, we,
             (h0 || h1) ? "hit" : "miss", v);
    issue(addr, we);
    drain();
  endtask

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_bus.cpu_req_valid = 1'b0;
    cpu_bus.cpu_req_addr  = '0;
    cpu_bus.cpu_req_we    = 1'b0;
    model_reset();

    // Reset: everything low, including ready
    repeat (3) @(negedge clk);
    #2;
    check_eq("reset_outputs", all_outputs(), 64'd0);
    #1 rst = 1'b1;
    @(negedge clk); #2;
    check_eq("ready_after_reset", 64'(cpu_bus.cpu_req_ready), 64'd1);

    // Cold miss, then hit, then same-set fills and clean eviction
    access(32'h0000_1040, 1'b0);
    access(32'h0000_1040, 1'b0);
    access(32'h0000_2040, 1'b0);
    access(32'h0000_3040, 1'b0);

    // Dirty way1 gets written back when evicted
    access(32'h0000_2040, 1'b1);
    access(32'h0000_4040, 1'b0);
    access(32'h0000_5040, 1'b0);

    // Stalls mid-writeback and mid-refill
    access(32'h0000_4040, 1'b1);
    access(32'h0000_5040, 1'b1);
    stall_arm = 2;
    access(32'h0000_6040, 1'b0);
    stall_arm = 0;

    // Store miss leaves the new line dirty; later evictions write it back
    access(32'h0000_7040, 1'b1);
    access(32'h0000_1040, 1'b0);
    access(32'h0000_2040, 1'b0);

    // Top set, unaligned offsets and an all-ones tag
    access(32'h0000_FFFC, 1'b0);
    access(32'hFFFF_FFF8, 1'b1);
    access(32'h0000_FFF4, 1'b0);
    access(32'h0001_0FF0, 1'b0);

    // Reset in the middle of a refill (set 8 is empty: refill goes to way0)
    exp_q.push_back(ev_req(1'b0, 32'h0000_6080));
    exp_q.push_back(ev_rf(1'b0, 2'd0));
    exp_q.push_back(ev_rf(1'b0, 2'd1));
    $display("access addr=0x%08h we=0 refill interrupted by reset", 32'h0000_6080);
    issue(32'h0000_6080, 1'b0);
    drain();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_refill_outputs", all_outputs(), 64'd0);
    model_reset();
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk); #2;
    check_eq("ready_after_mid_reset", 64'(cpu_bus.cpu_req_ready), 64'd1);

    // Lines filled before the reset are gone
    access(32'h0000_1040, 1'b0);
    access(32'h0000_6080, 1'b0);
    access(32'h0000_6080, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
